// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and elaboration helpers for the UART receive path
package uart_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2
  } sampler_state_t;

  localparam int MIN_SYNC_STAGES = 2;

  function automatic int mid_of(input int ovs);
    return ovs / 2;
  endfunction

  function automatic int win_lo(input int ovs, input int votes);
    return ovs / 2 - votes / 2;
  endfunction

  function automatic int win_hi(input int ovs, input int votes);
    return ovs / 2 + votes / 2;
  endfunction

  function automatic int cnt_width(input int ovs);
    return $clog2(ovs);
  endfunction

  function automatic int acc_width(input int votes);
    return $clog2(votes + 1);
  endfunction

  // The vote window must sit strictly inside the bit so the accumulator is
  // complete one phase before the wrap that consumes it.
  function automatic bit params_ok(input int ovs, input int votes, input int stages);
    return ((votes == 3) || (votes == 5)) &&
           (stages >= MIN_SYNC_STAGES) &&
           (win_lo(ovs, votes) >= 1) &&
           (win_hi(ovs, votes) <= ovs - 2);
  endfunction

endpackage

// File: rtl/uart_sync_chain.sv
// rtl/uart_sync_chain.sv - multi-flop synchroniser for an asynchronous input
module uart_sync_chain #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_bit_sampler.sv
// rtl/uart_rx_bit_sampler.sv - start-edge aligned oversampling bit sampler with majority vote
module uart_rx_bit_sampler
  import uart_pkg::*;
#(
  parameter int OVS         = 8,
  parameter int VOTES       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic rx_in,
  input  logic rx_resync,
  output logic start_det,
  output logic false_start,
  output logic bit_tick,
  output logic bit_val,
  output logic bit_noise
);

  localparam int CW = cnt_width(OVS);
  localparam int AW = acc_width(VOTES);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
  localparam logic [CW-1:0] WIN_LO   = CW'(win_lo(OVS, VOTES));
  localparam logic [CW-1:0] WIN_HI   = CW'(win_hi(OVS, VOTES));
  localparam logic [AW-1:0] ACC_HALF = AW'(VOTES / 2);
  localparam logic [AW-1:0] ACC_ALL  = AW'(VOTES);

  if (!params_ok(OVS, VOTES, SYNC_STAGES)) begin : g_param_check
    $error("uart_rx_bit_sampler: illegal OVS/VOTES/SYNC_STAGES combination");
  end

  logic rx_s;
  logic rx_prev;

  uart_sync_chain #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx_in),
    .q  (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_prev <= 1'b1;
    end else begin
      rx_prev <= rx_s;
    end
  end

  sampler_state_t  state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [AW-1:0]   acc, acc_n;
  logic            start_n, false_n, tick_n, val_n, noise_n;
  logic            wrap, in_win, vote, noise;

  assign wrap   = (cnt == CNT_LAST);
  assign in_win = (cnt >= WIN_LO) && (cnt <= WIN_HI);
  assign vote   = (acc > ACC_HALF);
  assign noise  = (acc != '0) && (acc != ACC_ALL);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc_n   = acc;
    start_n = 1'b0;
    false_n = 1'b0;
    tick_n  = 1'b0;
    val_n   = bit_val;
    noise_n = bit_noise;
    // A resync request is a one-cycle pulse, so it is honoured even while disabled.
    if (rx_resync) begin
      state_n = HUNT;
      cnt_n   = '0;
      acc_n   = '0;
    end else if (en) begin
      case (state)
        HUNT: begin
          cnt_n = '0;
          acc_n = '0;
          if (!rx_s && rx_prev) begin
            state_n = START;
            cnt_n   = CW'(1);
          end
        end
        START, DATA: begin
          cnt_n = wrap ? '0 : cnt + CW'(1);
          acc_n = wrap ? '0 : (in_win ? acc + AW'(rx_s) : acc);
          if (wrap) begin
            if (state == START) begin
              if (!vote) begin
                state_n = DATA;
                start_n = 1'b1;
              end else begin
                state_n = HUNT;
                false_n = 1'b1;
              end
            end else begin
              tick_n  = 1'b1;
              val_n   = vote;
              noise_n = noise;
            end
          end
        end
        default: begin
          state_n = HUNT;
          cnt_n   = '0;
          acc_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      cnt         <= '0;
      acc         <= '0;
      start_det   <= 1'b0;
      false_start <= 1'b0;
      bit_tick    <= 1'b0;
      bit_val     <= 1'b1;
      bit_noise   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      acc         <= acc_n;
      start_det   <= start_n;
      false_start <= false_n;
      bit_tick    <= tick_n;
      bit_val     <= val_n;
      bit_noise   <= noise_n;
    end
  end

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// tb/tb_uart_rx_bit_sampler.sv - checks two sampler configurations against a bit-period model
module tb_uart_rx_bit_sampler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b0, en_a = 1'b1, rs_a = 1'b0;
  logic rx_b = 1'b0, en_b = 1'b1, rs_b = 1'b0;
  logic start_a, false_a, tick_a, val_a, noise_a;
  logic start_b, false_b, tick_b, val_b, noise_b;

  always #5 clk = ~clk;

  uart_rx_bit_sampler #(.OVS(8), .VOTES(3), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .rx_in(rx_a), .rx_resync(rs_a),
    .start_det(start_a), .false_start(false_a), .bit_tick(tick_a),
    .bit_val(val_a), .bit_noise(noise_a)
  );

  uart_rx_bit_sampler #(.OVS(7), .VOTES(5), .SYNC_STAGES(3)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .rx_in(rx_b), .rx_resync(rs_b),
    .start_det(start_b), .false_start(false_b), .bit_tick(tick_b),
    .bit_val(val_b), .bit_noise(noise_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall0 = 0;
  bit model_ready = 1'b0;

  // Model: position since the alignment edge in enabled clocks; bit = pos/OVS, phase = pos%OVS.
  int   ovs_m[2]   = '{8, 7};
  int   votes_m[2] = '{3, 5};
  int   sync_m[2]  = '{2, 3};
  logic hist[2][8];
  bit   hunting[2];
  int   pos[2];
  int   sum[2];
  logic e_start[2], e_false[2], e_tick[2], e_val[2], e_noise[2];

  typedef struct {
    int   inst;
    int   kind;
    int   cyc;
    logic val;
    logic noise;
  } ev_t;
  ev_t evq[$];

  task automatic model_step(input int i, input logic rx, input logic en, input logic rs);
    logic rxs, rxp;
    int ph, lo, hi;
    if (rst) begin
      for (int j = 0; j < 8; j++) hist[i][j] = 1'b1;
      hunting[i] = 1'b1; pos[i] = 0; sum[i] = 0;
      e_start[i] = 0; e_false[i] = 0; e_tick[i] = 0; e_val[i] = 1; e_noise[i] = 0;
      return;
    end
    rxs = hist[i][sync_m[i]-1];
    rxp = hist[i][sync_m[i]];
    e_start[i] = 0; e_false[i] = 0; e_tick[i] = 0;
    lo = ovs_m[i] / 2 - votes_m[i] / 2;
    hi = ovs_m[i] / 2 + votes_m[i] / 2;
    if (rs) begin
      hunting[i] = 1'b1;
    end else if (en) begin
      if (hunting[i]) begin
        if (!rxs && rxp) begin
          hunting[i] = 1'b0; pos[i] = 0; sum[i] = 0;
        end
      end else begin
        pos[i]++;
        ph = pos[i] % ovs_m[i];
        if (ph >= lo && ph <= hi) sum[i] += int'(rxs);
        if (ph == ovs_m[i] - 1) begin
          if (pos[i] / ovs_m[i] == 0) begin
            if (sum[i] > votes_m[i] / 2) begin
              e_false[i] = 1'b1; hunting[i] = 1'b1;
              evq.push_back('{i, 1, cyc, 1'b0, 1'b0});
            end else begin
              e_start[i] = 1'b1;
              evq.push_back('{i, 0, cyc, 1'b0, 1'b0});
            end
          end else begin
            e_tick[i]  = 1'b1;
            e_val[i]   = (sum[i] > votes_m[i] / 2);
            e_noise[i] = (sum[i] != 0) && (sum[i] != votes_m[i]);
            evq.push_back('{i, 2, cyc, e_val[i], e_noise[i]});
          end
          sum[i] = 0;
        end
      end
    end
    for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
    hist[i][0] = rx;
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step(0, rx_a, en_a, rs_a);
    model_step(1, rx_b, en_b, rs_b);
    model_ready = 1'b1;
  end

  task automatic cmp(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_ready) begin
      cmp("a_start_det", start_a, e_start[0]);
      cmp("a_false_start", false_a, e_false[0]);
      cmp("a_bit_tick", tick_a, e_tick[0]);
      cmp("a_bit_val", val_a, e_val[0]);
      cmp("a_bit_noise", noise_a, e_noise[0]);
      cmp("b_start_det", start_b, e_start[1]);
      cmp("b_false_start", false_b, e_false[1]);
      cmp("b_bit_tick", tick_b, e_tick[1]);
      cmp("b_bit_val", val_b, e_val[1]);
      cmp("b_bit_noise", noise_b, e_noise[1]);
    end
  end

  task automatic lchk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ev_count(input int inst, input int kind);
    int n = 0;
    foreach (evq[k]) if (evq[k].inst == inst && evq[k].kind == kind) n++;
    return n;
  endfunction

  task automatic get_ev(input int inst, input int kind, input int n,
                        output int c, output logic v, output logic nz);
    int seen = 0;
    c = -1000; v = 1'bx; nz = 1'bx;
    foreach (evq[k]) begin
      if (evq[k].inst == inst && evq[k].kind == kind) begin
        if (seen == n) begin
          c = evq[k].cyc; v = evq[k].val; nz = evq[k].noise;
          return;
        end
        seen++;
      end
    end
  endtask

  task automatic check_frame(input int inst, input string tag, input int start_rel,
                             input int tick_rel[9], input logic [8:0] vals,
                             input logic [8:0] noises);
    int c;
    logic v, nz;
    lchk({tag, "_start_count"}, ev_count(inst, 0), 1);
    get_ev(inst, 0, 0, c, v, nz);
    lchk({tag, "_start_rel"}, c - fall0, start_rel);
    for (int k = 0; k < 9; k++) begin
      get_ev(inst, 2, k, c, v, nz);
      lchk($sformatf("%s_tick%0d_rel", tag, k), c - fall0, tick_rel[k]);
      lchk($sformatf("%s_tick%0d_val", tag, k), int'(v), int'(vals[k]));
      lchk($sformatf("%s_tick%0d_noise", tag, k), int'(nz), int'(noises[k]));
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int inst, input logic v, input logic e);
    if (inst == 0) begin rx_a = v; en_a = e; end
    else begin rx_b = v; en_b = e; end
  endtask

  task automatic send(input int inst, input logic [7:0] data, input int ovs,
                      input int inv0, input int inv1, input int stretch_per, input int en_off);
    logic [9:0] bits;
    int t;
    bits = {1'b1, data, 1'b0};
    fall0 = cyc + 1;
    t = 0;
    for (int p = 0; p < 10; p++) begin
      int len;
      len = ovs + ((p == stretch_per) ? 4 : 0);
      for (int c = 0; c < len; c++) begin
        drive(inst, bits[p] ^ ((t == inv0) || (t == inv1)),
              !(en_off >= 0 && t >= en_off && t < en_off + 4));
        step(1);
        t++;
      end
    end
    drive(inst, 1'b1, 1'b1);
  endtask

  task automatic resync(input int inst);
    if (inst == 0) rs_a = 1'b1; else rs_b = 1'b1;
    step(1);
    rs_a = 1'b0; rs_b = 1'b0;
    step(3);
  endtask

  int rel_a[9];
  int rel_b[9];
  int c0;
  logic v0, n0;

  initial begin
    for (int k = 0; k < 9; k++) rel_a[k] = 9 + 8 * (k + 1);
    rel_b = '{16, 23, 34, 41, 48, 55, 62, 69, 76};

    // Reset with the line low, release to idle.
    step(3);
    rst = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
    step(1);
    lchk("reset_bit_val", int'(val_a), 1);
    lchk("reset_pulses", int'(start_a) + int'(false_a) + int'(tick_a), 0);
    step(49);
    lchk("reset_no_start", ev_count(0, 0), 0);

    // Valid 0xA5 frame.
    evq.delete();
    send(0, 8'hA5, 8, -1, -1, -1, -1);
    step(10);
    check_frame(0, "valid", 9, rel_a, {1'b1, 8'hA5}, 9'b0);
    resync(0);

    // Glitch, then a real frame 20 clocks later.
    evq.delete();
    fall0 = cyc + 1;
    rx_a = 1'b0; step(2);
    rx_a = 1'b1; step(20);
    lchk("glitch_false_count", ev_count(0, 1), 1);
    get_ev(0, 1, 0, c0, v0, n0);
    lchk("glitch_false_rel", c0 - fall0, 9);
    lchk("glitch_no_start", ev_count(0, 0), 0);
    evq.delete();
    send(0, 8'h3C, 8, -1, -1, -1, -1);
    step(10);
    check_frame(0, "after_glitch", 9, rel_a, {1'b1, 8'h3C}, 9'b0);
    resync(0);

    // Phase-4 sample of data bit 3 inverted.
    evq.delete();
    send(0, 8'hA5, 8, 36, -1, -1, -1);
    step(10);
    check_frame(0, "noise", 9, rel_a, {1'b1, 8'hA5}, 9'b000001000);
    resync(0);

    // Resync on the data-bit-0 wrap, with a new start bit already on the line.
    evq.delete();
    fall0 = cyc + 1;
    rx_a = 1'b0; step(8);
    rx_a = 1'b1; step(8);
    rx_a = 1'b0; step(1);
    rs_a = 1'b1; step(1);
    rs_a = 1'b0; step(6);
    rx_a = 1'b1; step(40);
    lchk("rw_start_count", ev_count(0, 0), 2);
    get_ev(0, 0, 0, c0, v0, n0);
    lchk("rw_start0_rel", c0 - fall0, 9);
    get_ev(0, 0, 1, c0, v0, n0);
    lchk("rw_start1_rel", c0 - fall0, 25);
    get_ev(0, 2, 0, c0, v0, n0);
    lchk("rw_first_tick_rel", c0 - fall0, 33);
    resync(0);

    // OVS=7/VOTES=5/SYNC=3: phase-1 flip is voted, phase-6 flip is not; en low stretches bit 3.
    evq.delete();
    send(1, 8'h96, 7, 8, 52, 3, 26);
    step(10);
    check_frame(1, "sweep", 9, rel_b, {1'b1, 8'h96}, 9'b000000001);
    resync(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_bit_sampler.md
# uart_rx_bit_sampler

Parametrised UART receive front end. It synchronises the raw serial line, hunts for the start-bit falling edge, and aligns its oversampling phase to that edge. It takes a configurable majority vote around mid-bit, rejects false starts, and emits one registered bit decision per bit period with a noise flag. It sits between the RX pin and the UART receive frame FSM, which consumes `start_det`, `bit_tick`, `bit_val` and `bit_noise`, and drives `rx_resync` after a stop bit.

## Interface
- `OVS`, default 8: oversampling clocks per bit. Constraints: `floor(OVS/2) - VOTES/2 >= 1` and `floor(OVS/2) + VOTES/2 <= OVS-2`.
- `VOTES`, default 3: samples per vote. Legal values are 3 and 5.
- `SYNC_STAGES`, default 2: flops in the input synchroniser, minimum 2.
- `clk`  in  1  single clock (oversampling rate).
- `rst`  in  1  reset, synchronous and active-high.
- `en`  in  1  sampler enable. Low freezes the FSM, counter and accumulator.
- `rx_in`  in  1  asynchronous serial line; idle is 1.
- `rx_resync`  in  1  one-cycle request from the frame FSM to return to edge hunting.
- `start_det`  out  1  one-cycle pulse when the start bit is confirmed (vote = 0).
- `false_start`  out  1  one-cycle pulse when the start-bit vote = 1; the block returns to hunting.
- `bit_tick`  out  1  one-cycle pulse per data/stop bit; qualifies `bit_val` and `bit_noise`.
- `bit_val`  out  1  majority-voted bit; holds between ticks.
- `bit_noise`  out  1  vote was not unanimous; holds between ticks.

## Operation
- **Synchroniser:** `SYNC_STAGES` flops, all reset to 1. It always runs and ignores `en`. Its output is `rx_s`; `rx_prev` is `rx_s` delayed one clock and resets to 1.
- **Phase counter:** width `$clog2(OVS)`, wraps explicitly at `OVS-1` to 0, so non-power-of-2 `OVS` is legal.
- **Mid point and vote window:** `MID = floor(OVS/2)`. The vote window is counter values `MID-VOTES/2 .. MID+VOTES/2`.
- **Accumulator:** width `$clog2(VOTES+1)`. It adds `rx_s` on each window phase and clears on every counter wrap and on every entry to HUNT.
- **Vote result:** `vote = (acc > VOTES/2)`; `noise = (acc != 0 && acc != VOTES)`.
- **FSM states:** HUNT, START, DATA.
  - HUNT: counter held at 0. When `rx_s==0 && rx_prev==1`, go to START and load counter = 1; that edge is the alignment edge.
  - START: at counter == `OVS-1`, if `vote==0` go to DATA and pulse `start_det`; otherwise pulse `false_start` and go to HUNT. No `bit_tick` is issued for the start bit.
  - DATA: at every counter == `OVS-1`, pulse `bit_tick` and register `bit_val = vote` and `bit_noise = noise`. Remain in DATA until `rx_resync`.
- **Edges outside HUNT:** ignored. There is no mid-frame realignment.
- **`rx_resync`:** in any state, the next state is HUNT and the counter and accumulator clear. If it coincides with a wrap, `rx_resync` wins and no tick or start pulse is issued.
- **`en` low:** state, counter, accumulator and `bit_val`/`bit_noise` hold. All pulse outputs are 0. An edge occurring while `en` is low is lost unless `rx_s` is still low with `rx_prev` high when `en` returns.
- **Reset values:** state HUNT, counter 0, acc 0, `bit_val` 1, `bit_noise` 0, all pulses 0.
- **Reset mid-frame:** an immediate return to the reset values. No pulse is emitted on the reset cycle or the cycle after it.

## Timing
- All outputs are registered.
- A falling edge on `rx_in` captured at clock edge E0 is seen in HUNT at E(SYNC_STAGES), which is the alignment edge.
- `start_det` (or `false_start`) is high in the cycle after edge E(SYNC_STAGES+OVS-1).
- The following `bit_tick` pulses occur exactly every `OVS` clocks (with `en` held high).
- Vote samples for a bit are `rx_s` at counter phases `MID-VOTES/2..MID+VOTES/2` of that bit period.
- The HUNT → START decision has 1 cycle of latency from `rx_s` falling.
- `rx_resync` takes effect on the next clock. A new edge can align from the second clock after `rx_resync`.

## Structure
- Shared package `uart_pkg`:
  - sampler state enum (HUNT/START/DATA);
  - a localparam helper for `MID`, window bounds and counter/accumulator widths;
  - a parameter-check constants block used by elaboration-time assertions.
- Sub-module `uart_sync_chain` (params `STAGES`, `RST_VAL`): the reset-to-1 synchroniser, reusable for other asynchronous inputs.

## Test plan
All scenarios use `OVS=8`, `VOTES=3`, `SYNC_STAGES=2` unless stated.
- **Reset:** assert `rst` for 3 cycles with `rx_in=0`, then release with `rx_in=1` → `bit_val=1`, all pulses 0, no `start_det` for 50 cycles.
- **Valid frame:** `rx_in` low for 8 clocks, then data `0xA5` LSB-first, then a stop bit → `start_det` once, 9 `bit_tick`s spaced 8 clocks apart, `bit_val` = 1,0,1,0,0,1,0,1,1, `bit_noise=0`.
- **Glitch:** `rx_in` low for 2 clocks, then high → `false_start` exactly once, no `start_det`, back in HUNT. A valid start 20 clocks later is detected normally.
- **Noise:** one vote sample of data bit 3 inverted (sample at phase 4) → `bit_val` keeps the majority value and `bit_noise=1` on that tick only.
- **Resync coincident with wrap:** `rx_resync` on the wrap cycle in DATA → no `bit_tick`. An immediate new falling edge realigns, and `start_det` appears 9 clocks after the `rx_in` fall.
- **Parameter sweep:** `OVS=7`, `VOTES=5`, `SYNC_STAGES=3` → votes taken at phases 1..5, ticks every 7 clocks, results identical to a reference model. `en` low for 4 cycles mid-bit stretches that bit period by exactly 4 clocks.
